// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit (mc_controller).
// The optional CMP/NoWrite decode is enabled by defining MC_CTRL_NOWRITE_EN.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } mc_state_e;

    // Codes are 3 bits wide; the controller truncates them to ALUCTRL_W.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // ARM condition evaluation against {N,Z,C,V}; 1111 never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the IR/ALU side of the datapath and mc_controller.
// StateDbg and FlagsDbg expose the FSM state and stored flags for observation.
interface mc_controller_if #(parameter int ALUCTRL_W = 2);
    import mc_ctrl_pkg::*;

    logic [19:0]          Instr;
    logic [3:0]           ALUFlags;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 IRWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic [1:0]           ResultSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 InstrDone;
    mc_state_e            StateDbg;
    logic [3:0]           FlagsDbg;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, InstrDone,
               StateDbg, FlagsDbg
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, InstrDone,
               StateDbg, FlagsDbg
    );

endinterface

// File: rtl/mc_condlogic.sv
// Stored {N,Z}/{C,V} flag groups plus the CondEx bit latched at the end of DECODE.
module mc_condlogic
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       latch_cond_i,
    input  logic       flag_upd_i,
    output logic       cond_ex_o,
    output logic [3:0] flags_o
);
    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       cond_ex_q;

    // Flags are written with the CondEx of the current instruction, never the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz_q      <= 2'b00;
            cv_q      <= 2'b00;
            cond_ex_q <= 1'b0;
        end else begin
            if (latch_cond_i)
                cond_ex_q <= cond_eval(cond_i, {nz_q, cv_q});
            if (flag_upd_i && cond_ex_q && flag_w_i[1])
                nz_q <= alu_flags_i[3:2];
            if (flag_upd_i && cond_ex_q && flag_w_i[0])
                cv_q <= alu_flags_i[1:0];
        end
    end

    assign cond_ex_o = cond_ex_q;
    assign flags_o   = {nz_q, cv_q};

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: Moore main FSM plus ALU decoder, sequencing 3-5 cycles per instruction.
// Define MC_CTRL_NOWRITE_EN to decode CMP (cmd 1010, S=1) as a flag-only SUB.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 2
) (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd, rd, cond, rn_unused;
    logic       rd_pc;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rn_unused = bus.Instr[7:4];
    assign rd        = bus.Instr[3:0];
    assign cmd       = funct[4:1];
    assign rd_pc     = (rd == 4'hF);

    mc_state_e  state_q;
    logic       cond_ex;
    logic [3:0] flags;
    logic [2:0] alu_op;
    logic       no_write;
    logic [1:0] flag_w;

    always_comb begin
        alu_op   = ALU_ADD;
        no_write = 1'b0;
        case (cmd)
            4'b0100: alu_op = ALU_ADD;
            4'b0010: alu_op = ALU_SUB;
            4'b0000: alu_op = ALU_AND;
            4'b1100: alu_op = ALU_ORR;
            4'b0001: if (ALUCTRL_W >= 3) alu_op = ALU_EOR;
`ifdef MC_CTRL_NOWRITE_EN
            4'b1010: if (funct[0]) begin
                alu_op   = ALU_SUB;
                no_write = 1'b1;
            end
`endif
            default: alu_op = ALU_ADD;
        endcase
        // CMP is a subtraction, so it owns C/V as well as N/Z.
        flag_w[1] = funct[0];
        flag_w[0] = funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010) | no_write);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM:  state_q <= S_MEMADR;
                        OP_DP:   state_q <= funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   state_q <= S_BRANCH;
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXECR,
                S_EXECI:  state_q <= S_ALUWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    mc_condlogic u_condlogic (
        .clk          (clk),
        .reset        (reset),
        .cond_i       (cond),
        .alu_flags_i  (bus.ALUFlags),
        .flag_w_i     (flag_w),
        .latch_cond_i (state_q == S_DECODE),
        .flag_upd_i   ((state_q == S_EXECR) || (state_q == S_EXECI)),
        .cond_ex_o    (cond_ex),
        .flags_o      (flags)
    );

    logic       pc_write, ir_write, mem_write, reg_write, instr_done;
    logic [2:0] alu_sel;

    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        alu_sel       = ALU_ADD;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = SRCB_RD2;
        case (state_q)
            S_FETCH: begin
                ir_write      = 1'b1;
                pc_write      = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                instr_done    = (op == OP_UND);
            end
            S_MEMADR: begin
                bus.ALUSrcB = SRCB_IMM;
                alu_sel     = funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD:  bus.AdrSrc = 1'b1;
            S_MEMWR: begin
                bus.AdrSrc = 1'b1;
                mem_write  = cond_ex;
                instr_done = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                reg_write     = cond_ex & ~rd_pc;
                pc_write      = cond_ex & rd_pc;
                instr_done    = 1'b1;
            end
            S_EXECR,
            S_EXECI: begin
                bus.ALUSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_sel     = alu_op;
            end
            S_ALUWB: begin
                bus.ResultSrc = RES_ALUOUT;
                reg_write     = cond_ex & ~no_write & ~rd_pc;
                pc_write      = cond_ex & ~no_write & rd_pc;
                instr_done    = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALU;
                pc_write      = cond_ex;
                instr_done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes drop the instant reset asserts, independent of the clock.
    assign bus.PCWrite    = pc_write & reset;
    assign bus.IRWrite    = ir_write & reset;
    assign bus.MemWrite   = mem_write & reset;
    assign bus.RegWrite   = reg_write & reset;
    assign bus.InstrDone  = instr_done & reset;
    assign bus.ALUControl = ALUCTRL_W'(alu_sel);
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
    assign bus.StateDbg   = state_q;
    assign bus.FlagsDbg   = flags;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: two instances (ALUCTRL_W=2 and 3) share one stimulus stream.
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    int          n_checks;
    int          n_errors;

    mc_controller_if #(.ALUCTRL_W(2)) bus2 ();
    mc_controller_if #(.ALUCTRL_W(3)) bus3 ();

    assign bus2.Instr    = instr;
    assign bus2.ALUFlags = alu_flags;
    assign bus3.Instr    = instr;
    assign bus3.ALUFlags = alu_flags;

    mc_controller #(.ALUCTRL_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    mc_controller #(.ALUCTRL_W(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] w);
        instr = w[31:12];
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr = 20'h0;
        alu_flags = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus2.StateDbg !== S_FETCH) begin
            n_errors++; $display("FAIL reset_state: got %0d want %0d", bus2.StateDbg, S_FETCH);
        end
        n_checks++;
        if ({bus2.PCWrite, bus2.IRWrite, bus2.MemWrite, bus2.RegWrite, bus2.InstrDone} !== 5'b0) begin
            n_errors++; $display("FAIL reset_writes: got %b want 00000",
                {bus2.PCWrite, bus2.IRWrite, bus2.MemWrite, bus2.RegWrite, bus2.InstrDone});
        end
        n_checks++;
        if ({bus2.ALUSrcA, bus2.ALUSrcB, bus2.ResultSrc, bus2.AdrSrc} !== 6'b1_10_10_0) begin
            n_errors++; $display("FAIL reset_fetch_sel: got %b want 110100",
                {bus2.ALUSrcA, bus2.ALUSrcB, bus2.ResultSrc, bus2.AdrSrc});
        end
        n_checks++;
        if (bus2.FlagsDbg !== 4'h0) begin
            n_errors++; $display("FAIL reset_flags: got %b want 0000", bus2.FlagsDbg);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus2.IRWrite, bus2.PCWrite} !== 2'b11) begin
            n_errors++; $display("FAIL release_fetch: got %b want 11", {bus2.IRWrite, bus2.PCWrite});
        end
    endtask

    task automatic test_add();
        mc_state_e exp_s[4] = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
        int wr_cnt = 0;
        int done_cnt = 0;
        set_instr(32'hE0821003);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus2.StateDbg !== exp_s[i]) begin
                n_errors++; $display("FAIL add_state%0d: got %0d want %0d", i, bus2.StateDbg, exp_s[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (bus2.ALUControl !== 2'd0) begin
                    n_errors++; $display("FAIL add_aluctl: got %0d want 0", bus2.ALUControl);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (bus2.RegWrite !== 1'b1) begin
                    n_errors++; $display("FAIL add_regwrite: got %b want 1", bus2.RegWrite);
                end
            end
            wr_cnt += int'(bus2.RegWrite);
            done_cnt += int'(bus2.InstrDone);
            step();
        end
        n_checks++;
        if (wr_cnt != 1 || done_cnt != 1) begin
            n_errors++; $display("FAIL add_pulses: got wr=%0d done=%0d want 1 1", wr_cnt, done_cnt);
        end
        n_checks++;
        if (bus2.StateDbg !== S_FETCH) begin
            n_errors++; $display("FAIL add_return: got %0d want %0d", bus2.StateDbg, S_FETCH);
        end
    endtask

    task automatic test_ldr();
        mc_state_e exp_s[5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
        set_instr(32'hE5904008);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus2.StateDbg !== exp_s[i]) begin
                n_errors++; $display("FAIL ldr_state%0d: got %0d want %0d", i, bus2.StateDbg, exp_s[i]);
            end
            if (i == 1) begin
                n_checks++;
                if ({bus2.RegSrc, bus2.ImmSrc} !== 4'b10_01) begin
                    n_errors++; $display("FAIL ldr_regsrc_immsrc: got %b want 1001", {bus2.RegSrc, bus2.ImmSrc});
                end
            end
            if (i == 2) begin
                n_checks++;
                if ({bus2.ALUSrcA, bus2.ALUSrcB, bus2.ALUControl} !== 5'b0_01_00) begin
                    n_errors++; $display("FAIL ldr_memadr: got %b want 00100",
                        {bus2.ALUSrcA, bus2.ALUSrcB, bus2.ALUControl});
                end
            end
            if (i == 3) begin
                n_checks++;
                if ({bus2.AdrSrc, bus2.RegWrite, bus2.MemWrite} !== 3'b100) begin
                    n_errors++; $display("FAIL ldr_memrd: got %b want 100", {bus2.AdrSrc, bus2.RegWrite, bus2.MemWrite});
                end
            end
            if (i == 4) begin
                n_checks++;
                if ({bus2.ResultSrc, bus2.RegWrite, bus2.PCWrite, bus2.InstrDone} !== 5'b01_1_0_1) begin
                    n_errors++; $display("FAIL ldr_memwb: got %b want 01101",
                        {bus2.ResultSrc, bus2.RegWrite, bus2.PCWrite, bus2.InstrDone});
                end
            end
            step();
        end
        n_checks++;
        if (bus2.StateDbg !== S_FETCH) begin
            n_errors++; $display("FAIL ldr_return: got %0d want %0d", bus2.StateDbg, S_FETCH);
        end
    endtask

    task automatic test_cond_store();
        logic [31:0] ins[4] = '{32'hE0500000, 32'h05801000, 32'hE0900001, 32'h05801000};
        logic [3:0]  fl[4]  = '{4'b0110, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  exp_fl[4] = '{4'b0110, 4'b0110, 4'b0000, 4'b0000};
        logic        exp_mw[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            set_instr(ins[k]);
            alu_flags = fl[k];
            for (int i = 0; i < 4; i++) begin
                if (i == 2 && k == 0) begin
                    n_checks++;
                    if (bus2.ALUControl !== 2'd1) begin
                        n_errors++; $display("FAIL subs_aluctl: got %0d want 1", bus2.ALUControl);
                    end
                end
                if (i == 3) begin
                    n_checks++;
                    if (bus2.StateDbg !== ((k % 2 == 0) ? S_ALUWB : S_MEMWR) || bus2.InstrDone !== 1'b1) begin
                        n_errors++; $display("FAIL cond_last%0d: got state=%0d done=%b want state=%0d done=1",
                            k, bus2.StateDbg, bus2.InstrDone, (k % 2 == 0) ? S_ALUWB : S_MEMWR);
                    end
                    n_checks++;
                    if (bus2.MemWrite !== exp_mw[k]) begin
                        n_errors++; $display("FAIL cond_memwrite%0d: got %b want %b", k, bus2.MemWrite, exp_mw[k]);
                    end
                end
                step();
            end
            n_checks++;
            if (bus2.FlagsDbg !== exp_fl[k] || bus2.StateDbg !== S_FETCH) begin
                n_errors++; $display("FAIL cond_flags%0d: got flags=%b state=%0d want flags=%b state=%0d",
                    k, bus2.FlagsDbg, bus2.StateDbg, exp_fl[k], S_FETCH);
            end
        end
    endtask

    task automatic test_branch();
        mc_state_e exp_s[3] = '{S_FETCH, S_DECODE, S_BRANCH};
        set_instr(32'hEA000002);
        alu_flags = 4'h0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus2.StateDbg !== exp_s[i]) begin
                n_errors++; $display("FAIL b_state%0d: got %0d want %0d", i, bus2.StateDbg, exp_s[i]);
            end
            if (i == 2) begin
                n_checks++;
                if ({bus2.PCWrite, bus2.ALUSrcA, bus2.ALUSrcB, bus2.ResultSrc, bus2.InstrDone, bus2.RegSrc}
                    !== 9'b1_0_01_10_1_01) begin
                    n_errors++; $display("FAIL b_outputs: got %b want 100110101",
                        {bus2.PCWrite, bus2.ALUSrcA, bus2.ALUSrcB, bus2.ResultSrc, bus2.InstrDone, bus2.RegSrc});
                end
            end
            step();
        end
        n_checks++;
        if (bus2.StateDbg !== S_FETCH) begin
            n_errors++; $display("FAIL b_return: got %0d want %0d", bus2.StateDbg, S_FETCH);
        end
    endtask

    task automatic test_cmp();
        logic [1:0] exp_ctl;
        logic       exp_wr;
`ifdef MC_CTRL_NOWRITE_EN
        exp_ctl = 2'd1;
        exp_wr  = 1'b0;
`else
        exp_ctl = 2'd0;
        exp_wr  = 1'b1;
`endif
        set_instr(32'hE1510001);
        alu_flags = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                n_checks++;
                if (bus2.StateDbg !== S_EXECR || bus2.ALUControl !== exp_ctl) begin
                    n_errors++; $display("FAIL cmp_exec: got state=%0d ctl=%0d want state=%0d ctl=%0d",
                        bus2.StateDbg, bus2.ALUControl, S_EXECR, exp_ctl);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (bus2.RegWrite !== exp_wr || bus2.PCWrite !== 1'b0) begin
                    n_errors++; $display("FAIL cmp_regwrite: got %b%b want %b0", bus2.RegWrite, bus2.PCWrite, exp_wr);
                end
            end
            step();
        end
        n_checks++;
        if (bus2.FlagsDbg[2] !== 1'b1) begin
            n_errors++; $display("FAIL cmp_zflag: got %b want 1", bus2.FlagsDbg[2]);
        end
    endtask

    task automatic test_edges();
        set_instr(32'hEC000000);
        step();
        n_checks++;
        if (bus2.StateDbg !== S_DECODE || bus2.InstrDone !== 1'b1 ||
            {bus2.PCWrite, bus2.IRWrite, bus2.MemWrite, bus2.RegWrite} !== 4'b0) begin
            n_errors++; $display("FAIL undef_decode: got state=%0d done=%b want state=%0d done=1 no writes",
                bus2.StateDbg, bus2.InstrDone, S_DECODE);
        end
        step();
        n_checks++;
        if (bus2.StateDbg !== S_FETCH) begin
            n_errors++; $display("FAIL undef_return: got %0d want %0d", bus2.StateDbg, S_FETCH);
        end
        set_instr(32'hF0821003);
        repeat (3) step();
        n_checks++;
        if ({bus2.StateDbg == S_ALUWB, bus2.RegWrite, bus2.PCWrite, bus2.InstrDone} !== 4'b1001) begin
            n_errors++; $display("FAIL nv_aluwb: got %b want 1001",
                {bus2.StateDbg == S_ALUWB, bus2.RegWrite, bus2.PCWrite, bus2.InstrDone});
        end
        step();
        set_instr(32'hE082F003);
        repeat (3) step();
        n_checks++;
        if ({bus2.StateDbg == S_ALUWB, bus2.RegWrite, bus2.PCWrite} !== 3'b101) begin
            n_errors++; $display("FAIL rd15_aluwb: got %b want 101",
                {bus2.StateDbg == S_ALUWB, bus2.RegWrite, bus2.PCWrite});
        end
        step();
    endtask

    task automatic test_eor();
        set_instr(32'hE0210003);
        repeat (2) step();
        n_checks++;
        if (bus3.StateDbg !== S_EXECR || bus3.ALUControl !== 3'd4) begin
            n_errors++; $display("FAIL eor_w3: got state=%0d ctl=%0d want state=%0d ctl=4",
                bus3.StateDbg, bus3.ALUControl, S_EXECR);
        end
        n_checks++;
        if (bus2.ALUControl !== 2'd0) begin
            n_errors++; $display("FAIL eor_w2: got %0d want 0", bus2.ALUControl);
        end
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        set_instr(32'hE5904008);
        repeat (3) step();
        n_checks++;
        if (bus2.StateDbg !== S_MEMRD || bus2.AdrSrc !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_memrd: got state=%0d adr=%b want state=%0d adr=1",
                bus2.StateDbg, bus2.AdrSrc, S_MEMRD);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus2.PCWrite, bus2.IRWrite, bus2.MemWrite, bus2.RegWrite, bus2.InstrDone} !== 5'b0 ||
            bus2.StateDbg !== S_FETCH || bus2.FlagsDbg !== 4'h0) begin
            n_errors++; $display("FAIL rstmid_assert: got writes=%b state=%0d flags=%b want 00000 %0d 0000",
                {bus2.PCWrite, bus2.IRWrite, bus2.MemWrite, bus2.RegWrite, bus2.InstrDone},
                bus2.StateDbg, bus2.FlagsDbg, S_FETCH);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus2.StateDbg !== S_FETCH || bus2.IRWrite !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_release: got state=%0d ir=%b want state=%0d ir=1",
                bus2.StateDbg, bus2.IRWrite, S_FETCH);
        end
        step();
        n_checks++;
        if (bus2.StateDbg !== S_DECODE) begin
            n_errors++; $display("FAIL rstmid_first_fetch: got %0d want %0d", bus2.StateDbg, S_DECODE);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_add();
        test_ldr();
        test_cond_store();
        test_branch();
        test_cmp();
        test_edges();
        test_eor();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
